// File: rtl/usb4_tx_pkg.sv
// Shared encodings, FSM states and symbol-length helper for the USB4 TX symbol path.
package usb4_tx_pkg;

  localparam int SYM_BYTES_G3 = 16;
  localparam int SYM_BYTES_G2 = 8;
  localparam int CNT_W        = 5;
  localparam int STARVE_W     = 3;

  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [STARVE_W-1:0] starve_t;

  localparam starve_t STARVE_MAX = 3'd4;

  localparam logic [1:0] GEN_SPEED_G4   = 2'd0;
  localparam logic [1:0] GEN_SPEED_G3   = 2'd1;
  localparam logic [1:0] GEN_SPEED_G2   = 2'd2;
  localparam logic [1:0] GEN_SPEED_RSVD = 2'd3;

  localparam logic [3:0] D_SEL_TRANSPORT = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

  // Gen4 runs in byte mode, so every byte is a complete symbol.
  function automatic cnt_t sym_len_f(input logic [1:0] gen_speed);
    case (gen_speed)
      GEN_SPEED_G3: sym_len_f = cnt_t'(SYM_BYTES_G3);
      GEN_SPEED_G2: sym_len_f = cnt_t'(SYM_BYTES_G2);
      default:      sym_len_f = cnt_t'(1);
    endcase
  endfunction

endpackage

// File: rtl/enc_symbol_scheduler_sym_arbiter.sv
// Combinational grant between the ordered-set source and the transport FIFO,
// with a starvation override that forces one TL symbol after STARVE_MAX OS symbols.
module enc_symbol_scheduler_sym_arbiter
  import usb4_tx_pkg::*;
(
  input  logic    arb_en_i,
  input  logic    os_req_i,
  input  logic    tl_req_i,
  input  starve_t starve_cnt_i,
  output logic    grant_os_o,
  output logic    grant_tl_o
);

  logic starved;

  always_comb begin
    grant_os_o = 1'b0;
    grant_tl_o = 1'b0;
    starved    = (starve_cnt_i == STARVE_MAX);
    if (arb_en_i) begin
      if (tl_req_i && starved) begin
        grant_tl_o = 1'b1;
      end else if (os_req_i) begin
        grant_os_o = 1'b1;
      end else if (tl_req_i) begin
        grant_tl_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_symbol_scheduler.sv
// Sequences OS / TL symbols into the encoder one symbol at a time; grants only
// change on symbol boundaries and a new symbol can start right after the last byte.
module enc_symbol_scheduler
  import usb4_tx_pkg::*;
(
  input  logic       enc_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] gen_speed,
  input  logic       os_req,
  input  logic [3:0] os_type,
  input  logic [7:0] os_l0,
  input  logic [7:0] os_l1,
  output logic       os_rd,
  input  logic       tl_req,
  input  logic [7:0] tl_l0,
  input  logic [7:0] tl_l1,
  output logic       tl_rd,
  output logic [7:0] lane_0_tx,
  output logic [7:0] lane_1_tx,
  output logic [3:0] d_sel,
  output logic       enc_en,
  output logic       sym_start,
  output logic       sym_last,
  output state_e     dbg_state
);

  // Handshake: a source raises req only with a whole symbol buffered; while rd is
  // high it presents the current byte pair and advances at the next enc_clk edge.
  state_e     state_q, state_d;
  cnt_t       byte_cnt_q, byte_cnt_d;
  cnt_t       sym_len_q, sym_len_d;
  logic [3:0] sym_dsel_q, sym_dsel_d;
  logic       src_tl_q, src_tl_d;
  starve_t    starve_q, starve_d;

  logic [7:0] lane0_q, lane1_q;
  logic [3:0] d_sel_q;
  logic       enc_en_q, sym_start_q, sym_last_q;

  logic speed_ok, xfer, last_byte, arb_en, grant_os, grant_tl, grant;

  assign speed_ok  = (gen_speed != GEN_SPEED_RSVD);
  assign xfer      = (state_q == XFER) && enable;
  assign last_byte = xfer && (byte_cnt_q == sym_len_q - cnt_t'(1));
  // Arbitrating during the last byte is what removes the gap between symbols.
  assign arb_en    = enable && speed_ok && ((state_q == ARB) || last_byte);
  assign grant     = grant_os || grant_tl;

  enc_symbol_scheduler_sym_arbiter u_sym_arbiter (
    .arb_en_i     (arb_en),
    .os_req_i     (os_req),
    .tl_req_i     (tl_req),
    .starve_cnt_i (starve_q),
    .grant_os_o   (grant_os),
    .grant_tl_o   (grant_tl)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sym_len_d  = sym_len_q;
    sym_dsel_d = sym_dsel_q;
    src_tl_d   = src_tl_q;
    if (!enable) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (speed_ok) state_d = ARB;
        end
        ARB: begin
          if (!speed_ok) state_d = IDLE;
        end
        XFER: begin
          if (last_byte) begin
            byte_cnt_d = '0;
            state_d    = speed_ok ? ARB : IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + cnt_t'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (grant) begin
        state_d    = XFER;
        byte_cnt_d = '0;
        sym_len_d  = sym_len_f(gen_speed);
        sym_dsel_d = grant_tl ? D_SEL_TRANSPORT : os_type;
        src_tl_d   = grant_tl;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_tl || !tl_req) begin
      starve_d = '0;
    end else if (grant_os && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + starve_t'(1);
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      sym_len_q  <= cnt_t'(1);
      sym_dsel_q <= '0;
      src_tl_q   <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sym_len_q  <= sym_len_d;
      sym_dsel_q <= sym_dsel_d;
      src_tl_q   <= src_tl_d;
      starve_q   <= starve_d;
    end
  end

  assign os_rd = xfer && !src_tl_q;
  assign tl_rd = xfer && src_tl_q;

  // Output stage: bytes land one cycle after their rd; disabling clears everything.
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      lane0_q     <= '0;
      lane1_q     <= '0;
      d_sel_q     <= '0;
      enc_en_q    <= 1'b0;
      sym_start_q <= 1'b0;
      sym_last_q  <= 1'b0;
    end else if (!enable) begin
      lane0_q     <= '0;
      lane1_q     <= '0;
      d_sel_q     <= '0;
      enc_en_q    <= 1'b0;
      sym_start_q <= 1'b0;
      sym_last_q  <= 1'b0;
    end else begin
      enc_en_q    <= xfer;
      sym_start_q <= xfer && (byte_cnt_q == '0);
      sym_last_q  <= last_byte;
      if (xfer) begin
        lane0_q <= src_tl_q ? tl_l0 : os_l0;
        lane1_q <= src_tl_q ? tl_l1 : os_l1;
        d_sel_q <= sym_dsel_q;
      end
    end
  end

  assign lane_0_tx = lane0_q;
  assign lane_1_tx = lane1_q;
  assign d_sel     = d_sel_q;
  assign enc_en    = enc_en_q;
  assign sym_start = sym_start_q;
  assign sym_last  = sym_last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_enc_symbol_scheduler.sv
// Bench for enc_symbol_scheduler: counter-backed OS/TL sources, expected-byte
// queue filled by the directed stimulus, and a negedge monitor that drains it.
module tb_enc_symbol_scheduler;
  import usb4_tx_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic       enc_clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] gen_speed;
  logic       os_req, tl_req;
  logic [3:0] os_type;
  logic [7:0] os_l0, os_l1, tl_l0, tl_l1;
  logic       os_rd, tl_rd;
  logic [7:0] lane_0_tx, lane_1_tx;
  logic [3:0] d_sel;
  logic       enc_en, sym_start, sym_last;
  state_e     dbg_state;

  always #5 enc_clk = ~enc_clk;

  enc_symbol_scheduler dut (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .enable    (enable),
    .gen_speed (gen_speed),
    .os_req    (os_req),
    .os_type   (os_type),
    .os_l0     (os_l0),
    .os_l1     (os_l1),
    .os_rd     (os_rd),
    .tl_req    (tl_req),
    .tl_l0     (tl_l0),
    .tl_l1     (tl_l1),
    .tl_rd     (tl_rd),
    .lane_0_tx (lane_0_tx),
    .lane_1_tx (lane_1_tx),
    .d_sel     (d_sel),
    .enc_en    (enc_en),
    .sym_start (sym_start),
    .sym_last  (sym_last),
    .dbg_state (dbg_state)
  );

  // Sources: a byte counter per source that advances on each pop.
  logic [7:0] os_cnt = 8'd0;
  logic [7:0] tl_cnt = 8'd0;
  always @(posedge enc_clk) begin
    if (os_rd) os_cnt <= os_cnt + 8'd1;
    if (tl_rd) tl_cnt <= tl_cnt + 8'd1;
  end
  assign os_l0 = os_cnt;
  assign os_l1 = os_cnt ^ 8'hC0;
  assign tl_l0 = tl_cnt;
  assign tl_l1 = tl_cnt + 8'h40;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];
  logic [7:0]  os_m = 8'd0;
  logic [7:0]  tl_m = 8'd0;
  logic [21:0] mon_exp, mon_act;

  // Queue the first 'count' bytes of a symbol of length 'len' from one source.
  task automatic push_sym(input logic is_tl, input logic [3:0] ds, input int len, input int count);
    logic [7:0] b0, b1;
    for (int i = 0; i < count; i++) begin
      if (is_tl) begin
        b0 = tl_m; b1 = tl_m + 8'h40; tl_m = tl_m + 8'd1;
      end else begin
        b0 = os_m; b1 = os_m ^ 8'hC0; os_m = os_m + 8'd1;
      end
      exp_q.push_back({b0, b1, ds, (i == 0), (i == len - 1)});
    end
  endtask

  always @(negedge enc_clk) begin
    if (rst === 1'b1 && enc_en === 1'b1) begin
      checks++;
      mon_act = {lane_0_tx, lane_1_tx, d_sel, sym_start, sym_last};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got l0=%h l1=%h d_sel=%0d start=%b last=%b, expected no output",
                 lane_0_tx, lane_1_tx, d_sel, sym_start, sym_last);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL byte @%0t: got l0=%h l1=%h d_sel=%0d start=%b last=%b, expected l0=%h l1=%h d_sel=%0d start=%b last=%b",
                   $time, mon_act[21:14], mon_act[13:6], mon_act[5:2], mon_act[1], mon_act[0],
                   mon_exp[21:14], mon_exp[13:6], mon_exp[5:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_outputs"}, int'({lane_0_tx, lane_1_tx, d_sel, enc_en, sym_start, sym_last, os_rd, tl_rd}), 0);
    chk({name, "_state"}, int'(dbg_state), int'(IDLE));
  endtask

  task automatic wait_rd(input int n, input string name);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge enc_clk);
      if (os_rd || tl_rd) seen++;
      cyc++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL %s: saw %0d rd strobes, expected %0d", name, seen, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge enc_clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge enc_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; enable = 1'b0; gen_speed = GEN_SPEED_G2;
    os_req = 1'b0; tl_req = 1'b0; os_type = 4'd0;
    repeat (2) @(negedge enc_clk);
    chk_quiet("reset");

    rst = 1'b1; enable = 1'b1;
    @(negedge enc_clk);
    chk("idle_to_arb", int'(dbg_state), int'(ARB));

    // 1: Gen2 TL symbol, bytes 0x00..0x07, d_sel 8
    push_sym(1'b1, 4'd8, 8, 8);
    tl_req = 1'b1;
    wait_rd(1, "t1_start");
    tl_req = 1'b0;
    wait_drain("t1");

    // 2: Gen3 both requesting: 4 OS symbols then 1 TL, twice
    gen_speed = GEN_SPEED_G3; os_type = 4'd2;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) push_sym(1'b0, 4'd2, 16, 16);
      push_sym(1'b1, 4'd8, 16, 16);
    end
    os_req = 1'b1; tl_req = 1'b1;
    wait_rd(145, "t2_run");
    os_req = 1'b0; tl_req = 1'b0;
    wait_drain("t2");

    // 3: speed change mid-symbol only takes effect at the next symbol
    gen_speed = GEN_SPEED_G2; os_type = 4'd3;
    push_sym(1'b0, 4'd3, 8, 8);
    push_sym(1'b0, 4'd3, 16, 16);
    os_req = 1'b1;
    wait_rd(4, "t3_mid");
    gen_speed = GEN_SPEED_G3;
    wait_rd(5, "t3_next");
    os_req = 1'b0;
    wait_drain("t3");

    // 4: abort at Gen3 byte 5, then a clean symbol after re-enable
    push_sym(1'b1, 4'd8, 16, 5);
    tl_req = 1'b1;
    wait_rd(1, "t4_start");
    tl_req = 1'b0;
    wait_rd(5, "t4_byte5");
    enable = 1'b0;
    @(negedge enc_clk);
    chk_quiet("t4_abort");
    repeat (2) @(negedge enc_clk);
    enable = 1'b1;
    push_sym(1'b1, 4'd8, 16, 16);
    tl_req = 1'b1;
    wait_rd(1, "t4_restart");
    tl_req = 1'b0;
    wait_drain("t4");

    // 5: Gen4 byte mode, alternating sources, one-byte symbols
    gen_speed = GEN_SPEED_G4;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        os_type = (k % 4 == 0) ? 4'd9 : 4'd15;
        os_req = 1'b1; tl_req = 1'b0;
        push_sym(1'b0, os_type, 1, 1);
      end else begin
        os_req = 1'b0; tl_req = 1'b1;
        push_sym(1'b1, 4'd8, 1, 1);
      end
      @(negedge enc_clk);
    end
    os_req = 1'b0; tl_req = 1'b0;
    wait_drain("t5");

    // 6: asynchronous reset in the middle of a Gen2 symbol
    gen_speed = GEN_SPEED_G2;
    push_sym(1'b1, 4'd8, 8, 2);
    tl_req = 1'b1;
    wait_rd(1, "t6_start");
    tl_req = 1'b0;
    wait_rd(2, "t6_byte2");
    #2 rst = 1'b0;
    #1 chk_quiet("t6_async_reset");
    @(negedge enc_clk);
    rst = 1'b1;
    @(negedge enc_clk);
    chk("t6_resume_arb", int'(dbg_state), int'(ARB));
    push_sym(1'b1, 4'd8, 8, 8);
    tl_req = 1'b1;
    wait_rd(1, "t6_restart");
    tl_req = 1'b0;
    wait_drain("t6");

    // reserved speed at a boundary parks the FSM in IDLE
    gen_speed = GEN_SPEED_RSVD;
    repeat (2) @(negedge enc_clk);
    chk("rsvd_speed_idle", int'(dbg_state), int'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
